// File: rtl/move_commit_ctrl.sv
// move_commit_ctrl: validates one move per handshake, issues it to the board updater and reports the outcome
module move_commit_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_piece,
    input  logic [5:0]       in_square,
    input  logic [95:0]      loc_w,
    input  logic [95:0]      loc_b,
    input  logic [15:0]      alive_w,
    input  logic [15:0]      alive_b,
    output logic             upd_en,
    output logic [3:0]       upd_piece,
    output logic [5:0]       upd_move,
    output logic             upd_player,
    input  logic             upd_done,
    output logic             turn,
    output logic             result_valid,
    output logic [1:0]       result_code,
    output logic [CNT_W-1:0] move_count
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, REPORT} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic [TW-1:0] timer;
    logic [95:0]   own_loc;
    logic [15:0]   own_alive;
    logic          dead;
    logic          occupied;
    // Legality of the latched move against the side-to-move's own pieces; opponent squares are the updater's concern
    always_comb begin
        own_loc   = turn ? loc_w : loc_b;
        own_alive = turn ? alive_w : alive_b;
        dead      = ~own_alive[upd_piece];
        occupied  = 1'b0;
        for (int q = 0; q < 16; q++)
            occupied = occupied | (own_alive[q] && own_loc[6*q +: 6] == upd_move);
    end
    // Request sequencing: accept, check, issue, wait for completion, report
    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            upd_en       <= 1'b0;
            upd_piece    <= '0;
            upd_move     <= '0;
            upd_player   <= 1'b1;
            turn         <= 1'b1;
            result_valid <= 1'b0;
            result_code  <= 2'b00;
            move_count   <= '0;
            timer        <= '0;
        end else begin
            upd_en       <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        upd_piece  <= in_piece;
                        upd_move   <= in_square;
                        upd_player <= turn;
                        in_ready   <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (dead || occupied) begin
                        result_code  <= dead ? 2'b01 : 2'b10;
                        result_valid <= 1'b1;
                        state        <= REPORT;
                    end else begin
                        upd_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (upd_done) begin
                        result_code  <= 2'b00;
                        result_valid <= 1'b1;
                        turn         <= ~turn;
                        move_count   <= move_count + CNT_W'(1);
                        state        <= REPORT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        result_code  <= 2'b11;
                        result_valid <= 1'b1;
                        state        <= REPORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPORT: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_commit_ctrl.sv
// tb_move_commit_ctrl: directed and randomized move requests checked against a transaction-level model
module tb_move_commit_ctrl;
    localparam int TO = 15;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_piece = '0;
    logic [5:0]  in_square = '0;
    logic [95:0] loc_w, loc_b;
    logic [15:0] alive_w, alive_b;
    logic        upd_en;
    logic [3:0]  upd_piece;
    logic [5:0]  upd_move;
    logic        upd_player;
    logic        upd_done = 1'b0;
    logic        turn;
    logic        result_valid;
    logic [1:0]  result_code;
    logic [15:0] move_count;
    int          n_checks = 0;
    int          n_err = 0;
    logic        m_turn;
    logic [15:0] m_count;

    move_commit_ctrl #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_piece(in_piece), .in_square(in_square),
        .loc_w(loc_w), .loc_b(loc_b), .alive_w(alive_w), .alive_b(alive_b),
        .upd_en(upd_en), .upd_piece(upd_piece), .upd_move(upd_move), .upd_player(upd_player),
        .upd_done(upd_done), .turn(turn), .result_valid(result_valid),
        .result_code(result_code), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Outcome from the rules alone: dead piece, own-occupied target, else done-or-timeout
    function automatic logic [1:0] expect_code(input logic side, input logic [3:0] p,
                                               input logic [5:0] s, input int dly);
        logic [95:0] l;
        logic [15:0] a;
        l = side ? loc_w : loc_b;
        a = side ? alive_w : alive_b;
        if (!a[p]) return 2'b01;
        for (int q = 0; q < 16; q++)
            if (a[q] && l[6*q +: 6] == s) return 2'b10;
        return (dly < TO) ? 2'b00 : 2'b11;
    endfunction

    task automatic init_board;
        for (int p = 0; p < 8; p++) begin
            loc_w[6*(p+8) +: 6] = 6'(23 - (p + 8));
            loc_b[6*(p+8) +: 6] = 6'(63 - (p + 8));
        end
        loc_w[6*7 +: 6] = 6'd0;  loc_w[6*6 +: 6] = 6'd7;
        loc_w[6*5 +: 6] = 6'd1;  loc_w[6*4 +: 6] = 6'd6;
        loc_w[6*3 +: 6] = 6'd2;  loc_w[6*2 +: 6] = 6'd5;
        loc_w[6*1 +: 6] = 6'd3;  loc_w[6*0 +: 6] = 6'd4;
        for (int p = 0; p < 8; p++)
            loc_b[6*p +: 6] = loc_w[6*p +: 6] + 6'd56;
        alive_w = 16'hFFFF;
        alive_b = 16'hFFFF;
    endtask

    task automatic rand_board;
        for (int p = 0; p < 16; p++) begin
            loc_w[6*p +: 6] = 6'($urandom);
            loc_b[6*p +: 6] = 6'($urandom);
        end
        alive_w = 16'($urandom | $urandom);
        alive_b = 16'($urandom | $urandom);
    endtask

    // One full request from handshake to return to IDLE, with ignored noise on in_valid/upd_done
    task automatic run_move(input logic [3:0] p, input logic [5:0] s, input int dly);
        logic [1:0] ec;
        ec = expect_code(m_turn, p, s, dly);
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1; in_piece = p; in_square = s;
        tick;
        in_valid = 1'($urandom); upd_done = 1'($urandom);
        in_piece = 4'($urandom); in_square = 6'($urandom);
        check("check_ready", in_ready, 0);
        check("check_en", upd_en, 0);
        check("check_rv", result_valid, 0);
        tick;
        if (ec == 2'b01 || ec == 2'b10) begin
            in_valid = 1'b0; upd_done = 1'b0;
            check("rej_rv", result_valid, 1);
            check("rej_code", result_code, ec);
            check("rej_en", upd_en, 0);
        end else begin
            check("issue_en", upd_en, 1);
            check("issue_piece", upd_piece, p);
            check("issue_move", upd_move, s);
            check("issue_player", upd_player, m_turn);
            tick;
            for (int i = 0; i < TO; i++) begin
                upd_done = (i == dly);
                in_valid = 1'($urandom);
                check("wait_en", upd_en, 0);
                check("wait_rv", result_valid, 0);
                check("wait_player", upd_player, m_turn);
                tick;
                if (i == dly) break;
            end
            upd_done = 1'b0; in_valid = 1'b0;
            check("done_rv", result_valid, 1);
            check("done_code", result_code, ec);
        end
        if (ec == 2'b00) begin
            m_turn = ~m_turn;
            m_count = m_count + 16'd1;
        end
        tick;
        check("post_rv", result_valid, 0);
        check("post_ready", in_ready, 1);
        check("post_turn", turn, m_turn);
        check("post_count", move_count, m_count);
        check("post_code", result_code, ec);
    endtask

    task automatic check_reset_state;
        check("rst_ready", in_ready, 1);
        check("rst_en", upd_en, 0);
        check("rst_piece", upd_piece, 0);
        check("rst_move", upd_move, 0);
        check("rst_player", upd_player, 1);
        check("rst_turn", turn, 1);
        check("rst_rv", result_valid, 0);
        check("rst_code", result_code, 0);
        check("rst_count", move_count, 0);
    endtask

    initial begin
        logic [3:0] p;
        logic [5:0] s;
        logic [3:0] q;
        init_board();
        m_turn = 1'b1;
        m_count = '0;
        tick; tick;
        RST = 1'b0;
        check_reset_state();
        run_move(4'd0, 6'd8, 0);
        alive_w[15] = 1'b0;
        run_move(4'd15, 6'd16, 0);
        alive_w[15] = 1'b1;
        run_move(4'd15, 6'd8, 0);
        run_move(4'd15, 6'd16, TO);
        run_move(4'd15, 6'd16, 3);
        run_move(4'd15, 6'd40, TO - 1);
        run_move(4'd8, 6'd23, 0);
        for (int n = 0; n < 80; n++) begin
            rand_board();
            p = 4'($urandom);
            q = 4'($urandom);
            s = ($urandom_range(0, 2) == 0) ? (m_turn ? loc_w[6*q +: 6] : loc_b[6*q +: 6]) : 6'($urandom);
            run_move(p, s, $urandom_range(0, TO + 2));
        end
        init_board();
        if (m_turn) run_move(4'd14, 6'd17, TO);
        else        run_move(4'd14, 6'd41, TO);
        check("pre_rst_count", move_count, m_count);
        in_valid = 1'b1; in_piece = 4'd9; in_square = m_turn ? 6'd22 : 6'd46;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        check_reset_state();
        upd_done = 1'b1;
        tick;
        upd_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("late_done_rv", result_valid, 0);
            check("late_done_en", upd_en, 0);
            tick;
        end
        check("late_done_count", move_count, 0);
        m_turn = 1'b1;
        m_count = '0;
        run_move(4'd15, 6'd16, 2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
